// File: rtl/dual_gate_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : dual_gate_sweeper
// Brief    : Drives all 16 input vectors into two 4-input gates, waits for the
//            outputs to settle, and captures one 16-bit truth table per gate.
//            Optional macro SWEEP_CHECK_EN adds a compare against expected tables.
// Revision : 1.0 - initial release
// ============================================================================
module dual_gate_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  P2_MASK       = 4'h0
`ifdef SWEEP_CHECK_EN
  ,
  parameter logic [15:0] EXP_TT1       = 16'h7FFF,
  parameter logic [15:0] EXP_TT2       = 16'h7FFF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        p1y,
  input  logic        p2y,
  output logic        p1a,
  output logic        p1b,
  output logic        p1c,
  output logic        p1d,
  output logic        p2a,
  output logic        p2b,
  output logic        p2c,
  output logic        p2d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt1,
  output logic [15:0] tt2
`ifdef SWEEP_CHECK_EN
  ,
  output logic        pass,
  output logic [4:0]  err_cnt
`endif
);

  localparam logic [7:0] C_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [7:0]  r_cnt;
  logic [3:0]  r_p1;
  logic [3:0]  r_p2;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_tt1;
  logic [15:0] r_tt2;
  logic [15:0] w_tt1_nxt;
  logic [15:0] w_tt2_nxt;
  logic [3:0]  w_idx_inc;

  assign w_idx_inc = r_idx + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_SETTLE;
      S_SETTLE:  if (r_cnt == C_SETTLE_LAST) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = (r_idx == 4'hF) ? S_DONE : S_SETTLE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Tables including the bit captured this cycle; the compare logic needs the
  // final bit on the same edge that enters DONE.
  always_comb begin
    w_tt1_nxt = r_tt1;
    w_tt2_nxt = r_tt2;
    if (r_state == S_CAPTURE) begin
      w_tt1_nxt[r_idx] = p1y;
      w_tt2_nxt[r_idx] = p2y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= 4'd0;
      r_cnt  <= 8'd0;
      r_p1   <= 4'd0;
      r_p2   <= 4'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_tt1  <= 16'h0000;
      r_tt2  <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx  <= 4'd0;
            r_cnt  <= 8'd0;
            r_p1   <= 4'd0;
            r_p2   <= P2_MASK;
            r_busy <= 1'b1;
            r_tt1  <= 16'h0000;
            r_tt2  <= 16'h0000;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 8'd1;
        end
        S_CAPTURE: begin
          r_tt1 <= w_tt1_nxt;
          r_tt2 <= w_tt2_nxt;
          if (r_idx == 4'hF) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_idx <= w_idx_inc;
            r_p1  <= w_idx_inc;
            r_p2  <= w_idx_inc ^ P2_MASK;
            r_cnt <= 8'd0;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef SWEEP_CHECK_EN
  logic       r_pass;
  logic [4:0] r_err_cnt;
  logic [4:0] w_err_nxt;

  assign w_err_nxt = 5'($countones(w_tt1_nxt ^ EXP_TT1))
                   + 5'($countones(w_tt2_nxt ^ EXP_TT2));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pass    <= 1'b0;
      r_err_cnt <= 5'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_pass    <= 1'b0;
      r_err_cnt <= 5'd0;
    end else if ((r_state == S_CAPTURE) && (r_idx == 4'hF)) begin
      r_pass    <= (w_tt1_nxt == EXP_TT1) && (w_tt2_nxt == EXP_TT2);
      r_err_cnt <= w_err_nxt;
    end
  end

  assign pass    = r_pass;
  assign err_cnt = r_err_cnt;
`endif

  assign {p1a, p1b, p1c, p1d} = r_p1;
  assign {p2a, p2b, p2c, p2d} = r_p2;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign tt1                  = r_tt1;
  assign tt2                  = r_tt2;

endmodule
`default_nettype wire

// File: tb/tb_dual_gate_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_gate_sweeper
// Brief    : Self-checking bench; two sweeper instances driving table-based
//            gate models, compared against truth tables derived from the gates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_gate_sweeper;

  localparam int         SA = 1;
  localparam logic [3:0] MA = 4'h0;
  localparam int         SB = 3;
  localparam logic [3:0] MB = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] g1 [2];
  logic [15:0] g2 [2];

  logic [3:0]  d1_a, d2_a, d1_b, d2_b;
  logic        y1_a, y2_a, y1_b, y2_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] tt1_a, tt2_a, tt1_b, tt2_b;
`ifdef SWEEP_CHECK_EN
  logic        pass_a, pass_b;
  logic [4:0]  err_a, err_b;
`endif

  // Gate models: arbitrary 4-input functions given as lookup tables.
  assign y1_a = g1[0][d1_a];
  assign y2_a = g2[0][d2_a];
  assign y1_b = g1[1][d1_b];
  assign y2_b = g2[1][d2_b];

  dual_gate_sweeper #(.SETTLE_CYCLES(SA), .P2_MASK(MA)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .p1y(y1_a), .p2y(y2_a),
    .p1a(d1_a[3]), .p1b(d1_a[2]), .p1c(d1_a[1]), .p1d(d1_a[0]),
    .p2a(d2_a[3]), .p2b(d2_a[2]), .p2c(d2_a[1]), .p2d(d2_a[0]),
    .busy(busy_a), .done(done_a), .tt1(tt1_a), .tt2(tt2_a)
`ifdef SWEEP_CHECK_EN
    , .pass(pass_a), .err_cnt(err_a)
`endif
  );

  dual_gate_sweeper #(.SETTLE_CYCLES(SB), .P2_MASK(MB)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .p1y(y1_b), .p2y(y2_b),
    .p1a(d1_b[3]), .p1b(d1_b[2]), .p1c(d1_b[1]), .p1d(d1_b[0]),
    .p2a(d2_b[3]), .p2b(d2_b[2]), .p2c(d2_b[1]), .p2d(d2_b[0]),
    .busy(busy_b), .done(done_b), .tt1(tt1_b), .tt2(tt2_b)
`ifdef SWEEP_CHECK_EN
    , .pass(pass_b), .err_cnt(err_b)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int k, input string pfx, input logic bz, input logic dn,
                            input logic [3:0] e1, input logic [3:0] e2,
                            input logic [15:0] et1, input logic [15:0] et2);
    if (k == 0) begin
      check({pfx, "_busy_a"}, 32'(busy_a), 32'(bz));
      check({pfx, "_done_a"}, 32'(done_a), 32'(dn));
      check({pfx, "_p1_a"},   32'(d1_a),   32'(e1));
      check({pfx, "_p2_a"},   32'(d2_a),   32'(e2));
      check({pfx, "_tt1_a"},  32'(tt1_a),  32'(et1));
      check({pfx, "_tt2_a"},  32'(tt2_a),  32'(et2));
    end else begin
      check({pfx, "_busy_b"}, 32'(busy_b), 32'(bz));
      check({pfx, "_done_b"}, 32'(done_b), 32'(dn));
      check({pfx, "_p1_b"},   32'(d1_b),   32'(e1));
      check({pfx, "_p2_b"},   32'(d2_b),   32'(e2));
      check({pfx, "_tt1_b"},  32'(tt1_b),  32'(et1));
      check({pfx, "_tt2_b"},  32'(tt2_b),  32'(et2));
    end
  endtask

  task automatic set_start(input int k, input logic v);
    if (k == 0) start_a = v;
    else        start_b = v;
  endtask

  // One sweep on instance k. Cycle c counts edges with the start-accept edge
  // as cycle 1, so done is expected in cycle 16*(S+1)+1.
  task automatic sweep(input int k, input logic [15:0] t1, input logic [15:0] t2,
                       input bit repulse, input int abort_at);
    int          s;
    int          len;
    logic [3:0]  m;
    logic [3:0]  j;
    logic [3:0]  ix;
    logic [15:0] e1;
    logic [15:0] e2;
    s  = (k == 0) ? SA : SB;
    m  = (k == 0) ? MA : MB;
    g1[k] = t1;
    g2[k] = t2;
    e1 = t1;
    for (int i = 0; i < 16; i++) begin
      j     = 4'(i) ^ m;
      e2[i] = t2[j];
    end
    len = 16 * (s + 1);

    @(negedge clk);
    set_start(k, 1'b1);
    @(posedge clk);
    #1;
    set_start(k, 1'b0);
    for (int c = 1; c <= len; c++) begin
      ix = 4'((c - 1) / (s + 1));
      check_inst(k, "run", 1'b1, 1'b0, ix, ix ^ m,
                 (k == 0) ? tt1_a : tt1_b, (k == 0) ? tt2_a : tt2_b);
      if (c == abort_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_inst(k, "abort", 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000);
        return;
      end
      set_start(k, repulse && (c == 5 || c == 20));
      @(posedge clk);
      #1;
    end
    set_start(k, 1'b0);
    check_inst(k, "done", 1'b0, 1'b1, 4'hF, 4'hF ^ m, e1, e2);
`ifdef SWEEP_CHECK_EN
    check("pass", 32'((k == 0) ? pass_a : pass_b), 32'((e1 == 16'h7FFF) && (e2 == 16'h7FFF)));
    check("err_cnt", 32'((k == 0) ? err_a : err_b),
          32'($countones(e1 ^ 16'h7FFF) + $countones(e2 ^ 16'h7FFF)));
`endif
    // A start arriving in DONE must be ignored.
    set_start(k, 1'b1);
    @(posedge clk);
    #1;
    set_start(k, 1'b0);
    check_inst(k, "after", 1'b0, 1'b0, 4'hF, 4'hF ^ m, e1, e2);
    @(posedge clk);
    #1;
    check_inst(k, "idle", 1'b0, 1'b0, 4'hF, 4'hF ^ m, e1, e2);
  endtask

  initial begin
    g1[0] = 16'h7FFF; g2[0] = 16'h7FFF;
    g1[1] = 16'h7FFF; g2[1] = 16'h7FFF;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_inst(0, "reset", 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000);
    check_inst(1, "reset", 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000);
`ifdef SWEEP_CHECK_EN
    check("reset_pass", 32'(pass_a), 32'(0));
    check("reset_err",  32'(err_a),  32'(0));
`endif

    sweep(0, 16'h7FFF, 16'h7FFF, 1'b0, 0);   // NAND4 on both gates
    sweep(1, 16'h8000, 16'h0001, 1'b0, 0);   // AND4 / NOR4 with inverting mask
    sweep(1, 16'h7FFF, 16'h7FFF, 1'b0, 0);   // NAND4, long settle
    sweep(0, 16'h7FFF, 16'hFFFF, 1'b0, 0);   // gate 2 stuck high
    sweep(0, 16'($urandom), 16'($urandom), 1'b1, 0);
    sweep(0, 16'($urandom), 16'($urandom), 1'b0, 12);
    sweep(0, 16'($urandom), 16'($urandom), 1'b0, 0);
    for (int n = 0; n < 6; n++) begin
      sweep(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'(n & 1), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
